// File: rtl/pc_ctrl_pkg.sv
// Shared constants and encodings for the fetch PC update controller.
// State and redirect-source encodings are also used by the testbench.
package pc_ctrl_pkg;

    localparam logic [31:0] PC_INIT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_PEND = 3'd1,
        SRC_BR   = 3'd2,
        SRC_JMP  = 3'd3,
        SRC_ERET = 3'd4,
        SRC_EXC  = 3'd5
    } src_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect mux: exc > eret > jmp > br > pending.
// Purely combinational; sequential fetch is left to the caller.
module pc_redirect_arb
    import pc_ctrl_pkg::*;
(
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic [31:0] exc_vec,
    input  logic        jmp_en,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        pend,
    input  logic [31:0] pend_tgt,
    output logic        valid,
    output logic [31:0] target,
    output logic        is_exc
);

    src_t src;

    always_comb begin
        src = SRC_SEQ;
        if (exc_req)       src = SRC_EXC;
        else if (eret)     src = SRC_ERET;
        else if (jmp_en)   src = SRC_JMP;
        else if (br_taken) src = SRC_BR;
        else if (pend)     src = SRC_PEND;
    end

    always_comb begin
        target = pend_tgt;
        unique case (src)
            SRC_EXC:  target = exc_vec;
            SRC_ERET: target = epc;
            SRC_JMP:  target = jmp_target;
            SRC_BR:   target = br_target;
            default:  target = pend_tgt;
        endcase
    end

    assign valid  = (src != SRC_SEQ);
    assign is_exc = (src == SRC_EXC) || (src == SRC_ERET);

endmodule

// File: rtl/pc_update_ctrl.sv
// Fetch PC sequencer: next-PC select, load enable, stall-pending redirects.
// Define PCCTRL_EXC_EN to honour exc_req/eret/epc and drive flush.
module pc_update_ctrl #(
    parameter logic [31:0] PC_INIT = pc_ctrl_pkg::PC_INIT,
    parameter logic [31:0] EXC_VEC = pc_ctrl_pkg::EXC_VEC,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_current,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp_en,
    input  logic [31:0]      jmp_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [31:0]      epc,
    output logic [31:0]      pc_next,
    output logic             update_en,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cycles
);

    import pc_ctrl_pkg::*;

    state_t      state, state_nx;
    logic [31:0] pend_tgt, pend_nx;
    logic        exc_on, eret_on;
    logic        arb_valid, arb_exc;
    logic [31:0] arb_target;
    logic        pulse;
    logic [31:0] pulse_tgt;

`ifdef PCCTRL_EXC_EN
    assign exc_on  = exc_req;
    assign eret_on = eret;
`else
    logic unused_exc;
    assign exc_on     = 1'b0;
    assign eret_on    = 1'b0;
    assign unused_exc = ^{exc_req, eret};
`endif

    pc_redirect_arb u_arb (
        .exc_req    (exc_on),
        .eret       (eret_on),
        .epc        (epc),
        .exc_vec    (EXC_VEC),
        .jmp_en     (jmp_en),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pend       (state == PEND),
        .pend_tgt   (pend_tgt),
        .valid      (arb_valid),
        .target     (arb_target),
        .is_exc     (arb_exc)
    );

    // jmp beats br when both pulse in one cycle
    assign pulse     = jmp_en | br_taken;
    assign pulse_tgt = jmp_en ? jmp_target : br_target;

    always_comb begin
        pc_next   = pc_current + 32'd4;
        update_en = 1'b0;
        flush     = 1'b0;
        state_nx  = state;
        pend_nx   = pend_tgt;
        if (reset) begin
            pc_next  = PC_INIT;
            state_nx = RUN;
            pend_nx  = '0;
        end else if (arb_exc) begin
            pc_next   = arb_target;
            update_en = 1'b1;
            flush     = 1'b1;
            state_nx  = RUN;
            pend_nx   = '0;
        end else if (stall) begin
            if (pulse) begin
                pend_nx  = pulse_tgt;
                state_nx = PEND;
            end
        end else begin
            update_en = 1'b1;
            state_nx  = RUN;
            if (arb_valid) pc_next = arb_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            pend_tgt     <= '0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nx;
            pend_tgt <= pend_nx;
            if (!update_en && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Table-driven bench for pc_update_ctrl with an expected-value queue.
// A second instance with CNT_W=2 shares the stimulus to check saturation.
module tb_pc_update_ctrl;

    import pc_ctrl_pkg::*;

    typedef struct {
        logic        rst, stall, br, jmp, exc, eret;
        logic [31:0] br_t, jmp_t, epc, pc;
        logic [31:0] exp_pc;
        logic        exp_upd, exp_fl, chk_pc;
        int          exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_current = 32'h0;
    logic        stall = 1'b0, br_taken = 1'b0, jmp_en = 1'b0;
    logic        exc_req = 1'b0, eret = 1'b0;
    logic [31:0] br_target = 32'h0, jmp_target = 32'h0, epc = 32'h0;
    logic [31:0] pc_next, pc_next2;
    logic        update_en, flush, update_en2, flush2;
    logic [15:0] stall_cycles;
    logic [1:0]  stall_cycles2;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pc_update_ctrl dut (
        .clk(clk), .reset(reset), .pc_current(pc_current), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp_en(jmp_en),
        .jmp_target(jmp_target), .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc_next(pc_next), .update_en(update_en), .flush(flush),
        .stall_cycles(stall_cycles)
    );

    pc_update_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .pc_current(pc_current), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp_en(jmp_en),
        .jmp_target(jmp_target), .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc_next(pc_next2), .update_en(update_en2), .flush(flush2),
        .stall_cycles(stall_cycles2)
    );

    function automatic vec_t v(
        input logic rst, input logic [31:0] pc, input logic stl,
        input logic br, input logic [31:0] br_t,
        input logic jmp, input logic [31:0] jmp_t,
        input logic exc, input logic er, input logic [31:0] ep,
        input logic upd, input logic chk, input logic [31:0] exp_pc,
        input logic fl, input int cnt);
        vec_t r;
        r.rst = rst; r.pc = pc; r.stall = stl;
        r.br = br; r.br_t = br_t; r.jmp = jmp; r.jmp_t = jmp_t;
        r.exc = exc; r.eret = er; r.epc = ep;
        r.exp_upd = upd; r.chk_pc = chk; r.exp_pc = exp_pc;
        r.exp_fl = fl; r.exp_cnt = cnt;
        return r;
    endfunction

    function automatic vec_t q(input logic [31:0] pc, input logic [31:0] exp_pc,
                               input int cnt);
        return v(0, pc, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, exp_pc, 0, cnt);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic apply(input vec_t r, input int idx);
        vec_t e;
        int   sat;
        @(posedge clk);
        #1;
        reset = r.rst; pc_current = r.pc; stall = r.stall;
        br_taken = r.br; br_target = r.br_t;
        jmp_en = r.jmp; jmp_target = r.jmp_t;
        exc_req = r.exc; eret = r.eret; epc = r.epc;
        sb.push_back(r);
        @(negedge clk);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty[%0d] got 0 want 1", idx);
            return;
        end
        e = sb.pop_front();
        sat = (e.exp_cnt > 3) ? 3 : e.exp_cnt;
        chk("update_en", idx, {31'b0, update_en}, {31'b0, e.exp_upd});
        chk("flush", idx, {31'b0, flush}, {31'b0, e.exp_fl});
        chk("stall_cycles", idx, {16'b0, stall_cycles}, e.exp_cnt);
        chk("stall_cycles_w2", idx, {30'b0, stall_cycles2}, sat);
        if (e.chk_pc) chk("pc_next", idx, pc_next, e.exp_pc);
    endtask

    initial begin
        int c;
        // reset / idle sequential fetch
        tbl.push_back(v(1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, PC_INIT, 0, 0));
        tbl.push_back(q(32'h3000, 32'h3004, 0));
        tbl.push_back(q(32'h3004, 32'h3008, 0));
        tbl.push_back(q(32'h3008, 32'h300C, 0));
        tbl.push_back(q(32'h300C, 32'h3010, 0));
        // plain two-cycle stall
        tbl.push_back(v(0, 32'h3010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 32'h3010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(q(32'h3010, 32'h3014, 2));
        // branch arrives mid-stall, held three cycles
        tbl.push_back(v(0, 32'h3014, 1, 1, 32'h3400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(v(0, 32'h3014, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(v(0, 32'h3014, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(q(32'h3014, 32'h3400, 5));
        // jmp and br together, no stall
        tbl.push_back(v(0, 32'h3400, 0, 1, 32'h3400, 1, 32'h3800, 0, 0, 0, 1, 1, 32'h3800, 0, 5));
        // latest pending wins
        tbl.push_back(v(0, 32'h3800, 1, 1, 32'h3500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(v(0, 32'h3800, 1, 0, 0, 1, 32'h3600, 0, 0, 0, 0, 0, 0, 0, 6));
        tbl.push_back(q(32'h3800, 32'h3600, 7));
        // fresh pulse on release beats pending, no replay after
        tbl.push_back(v(0, 32'h3600, 1, 0, 0, 1, 32'h3A00, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(v(0, 32'h3600, 0, 1, 32'h3B00, 0, 0, 0, 0, 0, 1, 1, 32'h3B00, 0, 8));
        tbl.push_back(q(32'h3B00, 32'h3B04, 8));
        // reset while pending
        tbl.push_back(v(0, 32'h3B04, 1, 1, 32'h3C00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
        tbl.push_back(v(1, 32'h3B04, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, PC_INIT, 0, 9));
        tbl.push_back(q(32'h3000, 32'h3004, 0));
        tbl.push_back(q(32'h3004, 32'h3008, 0));
        // exception during stall with a pending branch
        tbl.push_back(v(0, 32'h3008, 1, 1, 32'h3400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef PCCTRL_EXC_EN
        tbl.push_back(v(0, 32'h3008, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, EXC_VEC, 1, 1));
        tbl.push_back(q(EXC_VEC, EXC_VEC + 32'd4, 1));
        tbl.push_back(v(0, 32'h4184, 0, 0, 0, 1, 32'h3800, 0, 1, 32'h3300, 1, 1, 32'h3300, 1, 1));
        c = 1;
`else
        tbl.push_back(v(0, 32'h3008, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(q(32'h3008, 32'h3400, 2));
        tbl.push_back(v(0, 32'h3400, 0, 0, 0, 1, 32'h3800, 0, 1, 32'h3300, 1, 1, 32'h3800, 0, 2));
        c = 2;
`endif
        // sequential wrap
        tbl.push_back(q(32'hFFFF_FFFC, 32'h0000_0000, c));

        @(posedge clk);
        #1 reset = 1'b1;
        foreach (tbl[i]) apply(tbl[i], i);

        // jmp beats br while stalled; jmp target released later
        apply(v(0, 32'h1000, 1, 1, 32'h6000, 1, 32'h5000, 0, 0, 0, 0, 0, 0, 0, c), 100);
        apply(v(0, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5000, 0, c + 1), 101);
        apply(q(32'h5000, 32'h5004, c + 1), 102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
